// File: rtl/sb_pkg.sv
// Shared definitions for the sideband receive deserialiser.
// Holds the receive FSM state type and the default message/timing values.
// No ports.
package sb_pkg;

  localparam int SB_MSG_WIDTH      = 64;
  localparam int SB_GAP_CYCLES     = 256;  // 32 UI x 8 cycles
  localparam int SB_TIMEOUT_CYCLES = 64;
  localparam int SB_DEPTH          = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } sb_state_e;

endpackage

// File: rtl/sb_rx_deser_if.sv
// Receive-side message stream between the deserialiser FIFO and its consumer.
// Signals:
//   data_o  - FIFO head message        (master -> slave)
//   valid_o - FIFO not empty           (master -> slave)
//   level_o - FIFO occupancy           (master -> slave)
//   ready_i - consumer accepts head    (slave -> master)
interface sb_rx_deser_if
  import sb_pkg::*;
#(
  parameter int MSG_WIDTH = SB_MSG_WIDTH,
  parameter int DEPTH     = SB_DEPTH
);

  logic [MSG_WIDTH-1:0]   data_o;
  logic                   valid_o;
  logic [$clog2(DEPTH):0] level_o;
  logic                   ready_i;

  modport master (output data_o, output valid_o, output level_o, input ready_i);
  modport slave  (input data_o, input valid_o, input level_o, output ready_i);

endinterface

// File: rtl/sb_rx_fifo.sv
// First-word-fall-through FIFO holding completed sideband messages.
// Ports:
//   clk, rst_n      - clock, async active-low reset (clears storage too)
//   i_push, i_data  - write request and message
//   i_pop           - read request (ignored when empty)
//   o_data          - head entry
//   o_full, o_empty - occupancy flags
//   o_level         - number of stored entries
// A push while full is accepted only if a pop happens in the same cycle.
module sb_rx_fifo
  import sb_pkg::*;
#(
  parameter int WIDTH = SB_MSG_WIDTH,
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   LVL_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_DEPTH = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LVL_DEPTH);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Pointers are AW bits wide with DEPTH a power of two, so they wrap by themselves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/sb_rx_deser.sv
// Sideband receive deserialiser: samples an asynchronous forwarded clock and
// data pin, assembles MSB-first messages on falling clock edges, enforces an
// inter-message gap and an intra-message timeout, and queues complete
// messages in a FWFT FIFO.
// Ports:
//   clk_800MHz, reset_n  - sole clock, async active-low reset
//   enable_i             - receiver enable (low aborts any partial message)
//   dataPin_i, clkPin_i  - serial data / forwarded clock (idle high), async
//   rx_if (master)       - data_o, valid_o, level_o out; ready_i in
//   overflow_o           - sticky, a message was dropped on a full FIFO
//   framing_err_o        - one-cycle pulse on a timeout or gap violation
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for the first clock edge of a message
// ST_SHIFT | collecting bits; timeout counter watches for a stalled clock
// ST_GAP   | message done; edges here are early starts (framing error)
module sb_rx_deser
  import sb_pkg::*;
#(
  parameter int MSG_WIDTH      = SB_MSG_WIDTH,
  parameter int DEPTH          = SB_DEPTH,
  parameter int GAP_CYCLES     = SB_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = SB_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = 2
) (
  input  logic          clk_800MHz,
  input  logic          reset_n,
  input  logic          enable_i,
  input  logic          dataPin_i,
  input  logic          clkPin_i,
  sb_rx_deser_if.master rx_if,
  output logic          overflow_o,
  output logic          framing_err_o
);

  localparam int BCW = $clog2(MSG_WIDTH) + 1;
  localparam int GCW = $clog2(GAP_CYCLES) + 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(MSG_WIDTH - 1);
  localparam logic [GCW-1:0] GAP_ONE  = GCW'(1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);
  localparam logic [TCW-1:0] TO_ONE   = TCW'(1);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_dat_s;
  logic                   w_edge;

  sb_state_e              r_state;
  logic [BCW-1:0]         r_bit_cnt;
  logic [GCW-1:0]         r_gap_cnt;
  logic [TCW-1:0]         r_to_cnt;
  logic [MSG_WIDTH-1:0]   r_shift;
  logic [MSG_WIDTH-1:0]   w_shift_nxt;
  logic [MSG_WIDTH-1:0]   w_first_word;
  logic                   r_framing_err;
  logic                   r_overflow;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [MSG_WIDTH-1:0]   w_fifo_data;
  logic [$clog2(DEPTH):0] w_level;

  // Both pins go through identical chains so the data bit stays aligned
  // with the clock edge it belongs to. Idle-high reset avoids a false edge.
  always_ff @(posedge clk_800MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], clkPin_i};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], dataPin_i};
      r_clk_prev <= w_clk_s;
    end
  end

  assign w_clk_s      = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s      = r_dat_sync[SYNC_STAGES-1];
  assign w_edge       = r_clk_prev & ~w_clk_s;
  assign w_shift_nxt  = {r_shift[MSG_WIDTH-2:0], w_dat_s};
  assign w_first_word = {{(MSG_WIDTH-1){1'b0}}, w_dat_s};

  // The last bit is pushed straight from the shift path in the edge cycle.
  assign w_push = enable_i & (r_state == ST_SHIFT) & w_edge & (r_bit_cnt == BIT_LAST);

  always_ff @(posedge clk_800MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_gap_cnt     <= '0;
      r_to_cnt      <= '0;
      r_shift       <= '0;
      r_framing_err <= 1'b0;
    end else begin
      r_framing_err <= 1'b0;
      if (!enable_i) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= '0;
        r_gap_cnt <= '0;
        r_to_cnt  <= '0;
        r_shift   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_edge) begin
              r_shift   <= w_first_word;
              r_bit_cnt <= BIT_ONE;
              r_to_cnt  <= '0;
              r_state   <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (w_edge) begin
              r_shift  <= w_shift_nxt;
              r_to_cnt <= '0;
              if (r_bit_cnt == BIT_LAST) begin
                r_bit_cnt <= '0;
                r_gap_cnt <= '0;
                r_state   <= ST_GAP;
              end else begin
                r_bit_cnt <= r_bit_cnt + BIT_ONE;
              end
            end else if (r_to_cnt == TO_LAST) begin
              r_framing_err <= 1'b1;
              r_bit_cnt     <= '0;
              r_to_cnt      <= '0;
              r_shift       <= '0;
              r_state       <= ST_IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + TO_ONE;
            end
          end
          ST_GAP: begin
            // An early edge is flagged but still starts the next message.
            if (w_edge) begin
              r_framing_err <= 1'b1;
              r_shift       <= w_first_word;
              r_bit_cnt     <= BIT_ONE;
              r_to_cnt      <= '0;
              r_state       <= ST_SHIFT;
            end else if (r_gap_cnt == GAP_LAST) begin
              r_gap_cnt <= '0;
              r_state   <= ST_IDLE;
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_ONE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign w_pop = ~w_empty & rx_if.ready_i;

  always_ff @(posedge clk_800MHz or negedge reset_n) begin
    if (!reset_n) r_overflow <= 1'b0;
    else if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
  end

  sb_rx_fifo #(
    .WIDTH (MSG_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_800MHz),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_data  (w_shift_nxt),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign rx_if.data_o  = w_fifo_data;
  assign rx_if.valid_o = ~w_empty;
  assign rx_if.level_o = w_level;
  assign overflow_o    = r_overflow;
  assign framing_err_o = r_framing_err;

endmodule

// File: tb/tb_sb_rx_deser.sv
// Directed bench for sb_rx_deser: 8 cycles per UI, pins driven on the
// falling clk_800MHz edge, outputs sampled on the falling edge.
module tb_sb_rx_deser;

  localparam int MW    = 64;
  localparam int DEPTH = 4;
  localparam int TO    = 64;
  localparam int UI    = 8;

  logic clk_800MHz = 1'b0;
  logic reset_n    = 1'b0;
  logic enable_i   = 1'b0;
  logic dataPin_i  = 1'b1;
  logic clkPin_i   = 1'b1;
  logic overflow_o;
  logic framing_err_o;

  sb_rx_deser_if #(.MSG_WIDTH(MW), .DEPTH(DEPTH)) rx_if ();

  sb_rx_deser #(
    .MSG_WIDTH      (MW),
    .DEPTH          (DEPTH),
    .GAP_CYCLES     (256),
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (2)
  ) dut (
    .clk_800MHz    (clk_800MHz),
    .reset_n       (reset_n),
    .enable_i      (enable_i),
    .dataPin_i     (dataPin_i),
    .clkPin_i      (clkPin_i),
    .rx_if         (rx_if),
    .overflow_o    (overflow_o),
    .framing_err_o (framing_err_o)
  );

  always #1 clk_800MHz = ~clk_800MHz;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int fe_cnt    = 0;
  int fe_cyc    = 0;
  int last_fall = 0;

  logic [MW-1:0] msgs [8];

  always @(posedge clk_800MHz) cyc++;
  always @(negedge clk_800MHz) if (framing_err_o === 1'b1) begin fe_cnt++; fe_cyc = cyc; end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_800MHz);
  endtask

  // One UI: clock high with data set up, then clock low. Optionally pulse
  // ready across the single posedge on which this bit's edge is consumed.
  task automatic send_bit(input logic b, input logic pop_at_edge);
    dataPin_i = b;
    clkPin_i  = 1'b1;
    tick(UI / 2);
    clkPin_i  = 1'b0;
    last_fall = cyc;
    if (pop_at_edge) begin
      tick(2);
      rx_if.ready_i = 1'b1;
      tick(1);
      rx_if.ready_i = 1'b0;
      tick(UI / 2 - 3);
    end else begin
      tick(UI / 2);
    end
  endtask

  task automatic send_msg(input logic [MW-1:0] m, input int nbits, input logic pop_last);
    for (int i = 0; i < nbits; i++) send_bit(m[MW-1-i], pop_last && (i == nbits - 1));
    clkPin_i = 1'b1;
  endtask

  task automatic idle_ui(input int n);
    clkPin_i = 1'b1;
    tick(n * UI);
  endtask

  task automatic pop1();
    rx_if.ready_i = 1'b1;
    tick(1);
    rx_if.ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    checks++; if (rx_if.data_o !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", rx_if.data_o); end
    checks++; if (rx_if.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_if.valid_o); end
    checks++; if (rx_if.level_o !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", rx_if.level_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow_o); end
    checks++; if (framing_err_o !== 1'b0) begin failures++; $display("FAIL reset_framing got=%b exp=0", framing_err_o); end
    reset_n  = 1'b1;
    enable_i = 1'b1;
    tick(4);
  endtask

  task automatic test_single();
    int fe0;
    fe0 = fe_cnt;
    send_msg(64'hDEADBEEF01234567, MW, 1'b0);
    idle_ui(32);
    checks++; if (rx_if.data_o !== 64'hDEADBEEF01234567) begin failures++; $display("FAIL single_data got=%h exp=deadbeef01234567", rx_if.data_o); end
    checks++; if (rx_if.valid_o !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", rx_if.valid_o); end
    checks++; if (rx_if.level_o !== 3'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", rx_if.level_o); end
    checks++; if (fe_cnt - fe0 != 0) begin failures++; $display("FAIL single_framing got=%0d exp=0", fe_cnt - fe0); end
    pop1();
    checks++; if (rx_if.valid_o !== 1'b0 || rx_if.level_o !== 3'd0) begin failures++; $display("FAIL single_pop valid=%b level=%0d exp 0/0", rx_if.valid_o, rx_if.level_o); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      send_msg(msgs[i], MW, 1'b0);
      idle_ui(32);
    end
    checks++; if (rx_if.level_o !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d exp=4", rx_if.level_o); end
    checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_if.data_o !== msgs[i]) begin failures++; $display("FAIL ovf_order%0d got=%h exp=%h", i, rx_if.data_o, msgs[i]); end
      pop1();
    end
    checks++; if (rx_if.valid_o !== 1'b0) begin failures++; $display("FAIL ovf_fifth_absent valid=%b exp=0 head=%h", rx_if.valid_o, rx_if.data_o); end
  endtask

  task automatic test_timeout();
    int fe0;
    fe0 = fe_cnt;
    send_msg(msgs[5], 20, 1'b0);
    tick(150);
    checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL to_pulses got=%0d exp=1", fe_cnt - fe0); end
    checks++; if (fe_cyc - last_fall < TO + 2 || fe_cyc - last_fall > TO + 4) begin failures++; $display("FAIL to_delay got=%0d exp=%0d..%0d", fe_cyc - last_fall, TO + 2, TO + 4); end
    checks++; if (rx_if.level_o !== 3'd0) begin failures++; $display("FAIL to_nopush level=%0d exp=0", rx_if.level_o); end
    send_msg(msgs[6], MW, 1'b0);
    idle_ui(32);
    checks++; if (rx_if.level_o !== 3'd1 || rx_if.data_o !== msgs[6]) begin failures++; $display("FAIL to_next level=%0d data=%h exp 1/%h", rx_if.level_o, rx_if.data_o, msgs[6]); end
    checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL to_next_framing got=%0d exp=1", fe_cnt - fe0); end
    pop1();
  endtask

  task automatic test_early_start();
    int fe0;
    fe0 = fe_cnt;
    send_msg(msgs[1], MW, 1'b0);
    idle_ui(10);
    send_msg(msgs[7], MW, 1'b0);
    idle_ui(32);
    checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL early_pulses got=%0d exp=1", fe_cnt - fe0); end
    checks++; if (rx_if.level_o !== 3'd2) begin failures++; $display("FAIL early_level got=%0d exp=2", rx_if.level_o); end
    checks++; if (rx_if.data_o !== msgs[1]) begin failures++; $display("FAIL early_first got=%h exp=%h", rx_if.data_o, msgs[1]); end
    pop1();
    checks++; if (rx_if.data_o !== msgs[7]) begin failures++; $display("FAIL early_second got=%h exp=%h", rx_if.data_o, msgs[7]); end
    pop1();
  endtask

  task automatic test_full_push_pop();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      send_msg(msgs[i], MW, 1'b0);
      idle_ui(32);
    end
    checks++; if (rx_if.level_o !== 3'd4) begin failures++; $display("FAIL fullpp_pre_level got=%0d exp=4", rx_if.level_o); end
    send_msg(msgs[4], MW, 1'b1);
    idle_ui(32);
    checks++; if (rx_if.level_o !== 3'd4) begin failures++; $display("FAIL fullpp_level got=%0d exp=4", rx_if.level_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL fullpp_overflow got=%b exp=0", overflow_o); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (rx_if.data_o !== msgs[i]) begin failures++; $display("FAIL fullpp_order%0d got=%h exp=%h", i, rx_if.data_o, msgs[i]); end
      pop1();
    end
    checks++; if (rx_if.valid_o !== 1'b0) begin failures++; $display("FAIL fullpp_empty valid=%b exp=0", rx_if.valid_o); end
  endtask

  task automatic test_enable_abort();
    int fe0;
    fe0 = fe_cnt;
    send_msg(msgs[2], 30, 1'b0);
    enable_i = 1'b0;
    tick(4);
    enable_i = 1'b1;
    idle_ui(4);
    send_msg(msgs[3], MW, 1'b0);
    idle_ui(32);
    checks++; if (rx_if.level_o !== 3'd1 || rx_if.data_o !== msgs[3]) begin failures++; $display("FAIL enable_abort level=%0d data=%h exp 1/%h", rx_if.level_o, rx_if.data_o, msgs[3]); end
    checks++; if (fe_cnt - fe0 != 0) begin failures++; $display("FAIL enable_framing got=%0d exp=0", fe_cnt - fe0); end
    pop1();
  endtask

  task automatic test_reset_mid();
    int fe0;
    send_msg(msgs[0], MW, 1'b0);
    idle_ui(32);
    send_msg(msgs[5], 30, 1'b0);
    tick(2);
    reset_n = 1'b0;
    tick(2);
    checks++; if (rx_if.data_o !== '0) begin failures++; $display("FAIL rstmid_data got=%h exp=0", rx_if.data_o); end
    checks++; if (rx_if.valid_o !== 1'b0 || rx_if.level_o !== 3'd0) begin failures++; $display("FAIL rstmid_valid_level got=%b/%0d exp=0/0", rx_if.valid_o, rx_if.level_o); end
    checks++; if (overflow_o !== 1'b0 || framing_err_o !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=%b/%b exp=0/0", overflow_o, framing_err_o); end
    clkPin_i = 1'b1;
    reset_n  = 1'b1;
    idle_ui(2);
    fe0 = fe_cnt;
    send_msg(msgs[6], MW, 1'b0);
    idle_ui(32);
    checks++; if (rx_if.level_o !== 3'd1 || rx_if.data_o !== msgs[6]) begin failures++; $display("FAIL rstmid_next level=%0d data=%h exp 1/%h", rx_if.level_o, rx_if.data_o, msgs[6]); end
    checks++; if (fe_cnt - fe0 != 0) begin failures++; $display("FAIL rstmid_framing got=%0d exp=0", fe_cnt - fe0); end
    pop1();
  endtask

  initial begin
    rx_if.ready_i = 1'b0;
    msgs[0] = 64'h0123456789ABCDEF;
    msgs[1] = 64'hFEDCBA9876543210;
    msgs[2] = 64'hA5A5A5A55A5A5A5A;
    msgs[3] = 64'h8000000000000001;
    msgs[4] = 64'h00000000FFFFFFFF;
    msgs[5] = 64'hCAFEF00D12345678;
    msgs[6] = 64'h13579BDF2468ACE0;
    msgs[7] = 64'h7FFFFFFFFFFFFFFE;
    test_reset();
    test_single();
    test_overflow();
    test_timeout();
    test_early_start();
    test_full_push_pop();
    test_enable_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
